// File: rtl/proc_pkg.sv
// Shared fetch-stage types and default widths for the processor pipeline.
package proc_pkg;

  localparam int unsigned PC_WIDTH    = 10;
  localparam int unsigned INSTR_WIDTH = 16;
  localparam int unsigned PC_RESET    = 0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StDeliver = 2'd2,
    StFlush   = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PcHold    = 2'd0,
    PcInc     = 2'd1,
    PcBranch  = 2'd2,
    PcPending = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: hold, PC+1 (modulo 2^Width), live branch target or pending target.
module pc_next_sel
  import proc_pkg::*;
#(
  parameter int unsigned Width = proc_pkg::PC_WIDTH
) (
  input  pc_sel_e          sel_i,
  input  logic [Width-1:0] pc_i,
  input  logic [Width-1:0] branch_target_i,
  input  logic [Width-1:0] pending_i,
  output logic [Width-1:0] pc_inc_o,
  output logic [Width-1:0] pc_next_o
);

  assign pc_inc_o = pc_i + {{(Width-1){1'b0}}, 1'b1};

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      PcHold:    pc_next_o = pc_i;
      PcInc:     pc_next_o = pc_inc_o;
      PcBranch:  pc_next_o = branch_target_i;
      PcPending: pc_next_o = pending_i;
      default:   pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack memory reads and hands words to decode.
module instruction_fetch_unit #(
  parameter int unsigned PC_WIDTH    = proc_pkg::PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = proc_pkg::INSTR_WIDTH,
  parameter int unsigned PC_RESET    = proc_pkg::PC_RESET
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [PC_WIDTH-1:0]    iBranchTarget,
  output logic                   oMemReq,
  output logic [PC_WIDTH-1:0]    oMemAddr,
  input  logic                   iMemAck,
  input  logic [INSTR_WIDTH-1:0] iMemData,
  output logic [INSTR_WIDTH-1:0] oInstr,
  output logic                   oInstrValid,
  output logic [PC_WIDTH-1:0]    oPC,
  output logic [PC_WIDTH-1:0]    oNewPC
);
  import proc_pkg::*;

  localparam logic [PC_WIDTH-1:0] PcRstVal = PC_WIDTH'(PC_RESET);

  fetch_state_e           st_d, st_q;
  logic [PC_WIDTH-1:0]    pc_q, pc_next, pc_inc;
  logic [PC_WIDTH-1:0]    pend_d, pend_q;
  logic [INSTR_WIDTH-1:0] instr_d, instr_q;
  logic [PC_WIDTH-1:0]    opc_d, opc_q;
  logic [PC_WIDTH-1:0]    onew_d, onew_q;
  logic                   valid_d, valid_q;
  // Set for the single cycle in FETCH where the request is dropped after a discard.
  logic                   gap_d, gap_q;
  pc_sel_e                pc_sel;

  pc_next_sel #(
    .Width(PC_WIDTH)
  ) u_pc_next_sel (
    .sel_i          (pc_sel),
    .pc_i           (pc_q),
    .branch_target_i(iBranchTarget),
    .pending_i      (pend_q),
    .pc_inc_o       (pc_inc),
    .pc_next_o      (pc_next)
  );

  always_comb begin
    st_d    = st_q;
    pc_sel  = PcHold;
    pend_d  = pend_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    onew_d  = onew_q;
    valid_d = valid_q;
    gap_d   = 1'b0;
    unique case (st_q)
      StIdle: begin
        st_d = StFetch;
        if (iBranchTaken) pc_sel = PcBranch;
      end
      StFetch: begin
        if (gap_q) begin
          if (iBranchTaken) pc_sel = PcBranch;
        end else if (iMemAck && iBranchTaken) begin
          pc_sel = PcBranch;
          gap_d  = 1'b1;
        end else if (iMemAck) begin
          instr_d = iMemData;
          opc_d   = pc_q;
          onew_d  = pc_inc;
          pc_sel  = PcInc;
          valid_d = 1'b1;
          st_d    = StDeliver;
        end else if (iBranchTaken) begin
          pend_d = iBranchTarget;
          st_d   = StFlush;
        end
      end
      StFlush: begin
        if (iMemAck) begin
          // A branch arriving with the ack is newer than the pending one.
          pc_sel = iBranchTaken ? PcBranch : PcPending;
          gap_d  = 1'b1;
          st_d   = StFetch;
        end else if (iBranchTaken) begin
          pend_d = iBranchTarget;
        end
      end
      StDeliver: begin
        if (iBranchTaken) begin
          valid_d = 1'b0;
          pc_sel  = PcBranch;
          st_d    = StFetch;
        end else if (!iStall) begin
          valid_d = 1'b0;
          st_d    = StFetch;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      st_q    <= StIdle;
      pc_q    <= PcRstVal;
      pend_q  <= '0;
      instr_q <= '0;
      opc_q   <= '0;
      onew_q  <= '0;
      valid_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_next;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      onew_q  <= onew_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
    end
  end

  assign oMemReq     = ((st_q == StFetch) || (st_q == StFlush)) && !gap_q;
  assign oMemAddr    = pc_q;
  assign oInstr      = instr_q;
  assign oInstrValid = valid_q;
  assign oPC         = opc_q;
  assign oNewPC      = onew_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a hand-driven memory handshake.
module tb_instruction_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic        iStall;
  logic        iBranchTaken;
  logic [9:0]  iBranchTarget;
  logic        oMemReq;
  logic [9:0]  oMemAddr;
  logic        iMemAck;
  logic [15:0] iMemData;
  logic [15:0] oInstr;
  logic        oInstrValid;
  logic [9:0]  oPC;
  logic [9:0]  oNewPC;

  int vectors = 0;
  int errors  = 0;

  instruction_fetch_unit dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStall       (iStall),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget),
    .oMemReq      (oMemReq),
    .oMemAddr     (oMemAddr),
    .iMemAck      (iMemAck),
    .iMemData     (iMemData),
    .oInstr       (oInstr),
    .oInstrValid  (oInstrValid),
    .oPC          (oPC),
    .oNewPC       (oNewPC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Entered in FETCH just after an edge; returns in the cycle after the ack.
  task automatic do_fetch(input logic [9:0] a, input logic [15:0] d, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", 32'(oMemReq), 32'd1);
      chk("addr_wait", 32'(oMemAddr), 32'(a));
      chk("novalid_wait", 32'(oInstrValid), 32'd0);
      tick();
    end
    chk("req", 32'(oMemReq), 32'd1);
    chk("addr", 32'(oMemAddr), 32'(a));
    iMemAck  = 1'b1;
    iMemData = d;
    tick();
    iMemAck  = 1'b0;
    iMemData = 16'h0000;
  endtask

  task automatic chk_deliver(input logic [15:0] d, input logic [9:0] pc, input logic [9:0] npc);
    chk("valid", 32'(oInstrValid), 32'd1);
    chk("instr", 32'(oInstr), 32'(d));
    chk("opc", 32'(oPC), 32'(pc));
    chk("onewpc", 32'(oNewPC), 32'(npc));
    chk("req_off_in_deliver", 32'(oMemReq), 32'd0);
  endtask

  initial begin
    Reset         = 1'b0;
    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = 10'h000;
    iMemAck       = 1'b0;
    iMemData      = 16'h0000;
    #1 Reset = 1'b1;
    #1;
    chk("rst_req", 32'(oMemReq), 32'd0);
    chk("rst_addr", 32'(oMemAddr), 32'd0);
    chk("rst_valid", 32'(oInstrValid), 32'd0);
    chk("rst_instr", 32'(oInstr), 32'd0);
    chk("rst_opc", 32'(oPC), 32'd0);
    chk("rst_newpc", 32'(oNewPC), 32'd0);
    tick();
    Reset = 1'b0;
    chk("idle_req", 32'(oMemReq), 32'd0);
    tick();

    // Sequential fetch, ack one cycle after the request rises.
    for (int k = 0; k < 4; k++) begin
      do_fetch(10'(k), 16'hA000 + 16'(k), 1);
      chk_deliver(16'hA000 + 16'(k), 10'(k), 10'(k + 1));
      tick();
    end

    // Stall holds the delivered word at oPC=5.
    do_fetch(10'd4, 16'h4444, 0);
    chk_deliver(16'h4444, 10'd4, 10'd5);
    tick();
    do_fetch(10'd5, 16'hBEEF, 0);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_deliver(16'hBEEF, 10'd5, 10'd6);
      tick();
    end

    // Branch while stalled squashes the held word.
    iBranchTaken  = 1'b1;
    iBranchTarget = 10'h200;
    tick();
    iBranchTaken = 1'b0;
    chk("squash_valid", 32'(oInstrValid), 32'd0);
    chk("br200_req", 32'(oMemReq), 32'd1);
    chk("br200_addr", 32'(oMemAddr), 32'h200);
    do_fetch(10'h200, 16'h5555, 0);
    chk_deliver(16'h5555, 10'h200, 10'h201);

    // Unstalled branch out of DELIVER to address 7.
    iStall        = 1'b0;
    iBranchTaken  = 1'b1;
    iBranchTarget = 10'd7;
    tick();
    // Branch during the fetch of 7; ack arrives three cycles later with 0x1234.
    iBranchTarget = 10'h050;
    chk("f7_req", 32'(oMemReq), 32'd1);
    chk("f7_addr", 32'(oMemAddr), 32'd7);
    tick();
    iBranchTaken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush_req", 32'(oMemReq), 32'd1);
      chk("flush_addr", 32'(oMemAddr), 32'd7);
      chk("flush_valid", 32'(oInstrValid), 32'd0);
      tick();
    end
    chk("flush_addr_ack", 32'(oMemAddr), 32'd7);
    iMemAck  = 1'b1;
    iMemData = 16'h1234;
    tick();
    iMemAck = 1'b0;
    chk("gap_req", 32'(oMemReq), 32'd0);
    chk("gap_valid", 32'(oInstrValid), 32'd0);
    tick();
    chk("discard_valid", 32'(oInstrValid), 32'd0);
    do_fetch(10'h050, 16'h0A50, 0);
    chk_deliver(16'h0A50, 10'h050, 10'h051);
    tick();

    // Ack and branch together: data dropped, one-cycle request gap.
    chk("coinc_addr", 32'(oMemAddr), 32'h051);
    iMemAck       = 1'b1;
    iMemData      = 16'hDEAD;
    iBranchTaken  = 1'b1;
    iBranchTarget = 10'h3FF;
    tick();
    iMemAck      = 1'b0;
    iBranchTaken = 1'b0;
    chk("coinc_gap_req", 32'(oMemReq), 32'd0);
    chk("coinc_valid", 32'(oInstrValid), 32'd0);
    tick();

    // PC wrap at the top of the address space.
    do_fetch(10'h3FF, 16'h7777, 0);
    chk_deliver(16'h7777, 10'h3FF, 10'h000);
    tick();
    chk("wrap_addr", 32'(oMemAddr), 32'h000);
    chk("wrap_req", 32'(oMemReq), 32'd1);
    tick();

    // Reset mid-FETCH with a stale ack after release.
    Reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(oMemReq), 32'd0);
    chk("mid_rst_instr", 32'(oInstr), 32'd0);
    chk("mid_rst_opc", 32'(oPC), 32'd0);
    chk("mid_rst_newpc", 32'(oNewPC), 32'd0);
    chk("mid_rst_valid", 32'(oInstrValid), 32'd0);
    tick();
    Reset    = 1'b0;
    iMemAck  = 1'b1;
    iMemData = 16'hBAD0;
    tick();
    iMemAck = 1'b0;
    chk("stale_valid", 32'(oInstrValid), 32'd0);
    chk("post_rst_req", 32'(oMemReq), 32'd1);
    chk("post_rst_addr", 32'(oMemAddr), 32'd0);
    do_fetch(10'd0, 16'h0C0C, 0);
    chk_deliver(16'h0C0C, 10'd0, 10'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
